// File: rtl/sd_data_master_mb.sv
// sd_data_master_mb
// Data-transfer master for an SD host. Pulls one 64-bit descriptor
// (DMA address + card argument) from the tx or rx descriptor queue, issues
// the matching read/write command through the command host, and runs the
// data phase block by block. Multi-block transfers are closed with CMD12.
// Errors are reported as sticky interrupt flags.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   bd_{tx,rx}_dat/free/ack       descriptor queue read data, free count, data valid
//   bd_{tx,rx}_re/cmp             descriptor read request, completion pulse
//   blk_cnt, transfer_type        blocks per descriptor, rx command select
//   cmd_busy, we_ack, cmd_tsf_err command-host status / handshake
//   card_status                   [0] response valid, [4:1] card state
//   we_req, cmd_set, cmd_arg      command request, code and argument
//   sys_adr                       DMA base address
//   start_{tx,rx}_fifo            FIFO filler enables
//   tx_empt, rx_full              FIFO underrun / overrun
//   transm_complete, crc_ok, busy_n  data-host block status
//   ack_transfer                  per-block acknowledge
//   d_write, d_read               data-path direction
//   int_status, int_status_rst    sticky flags and their synchronous clear
//   cidat                         command-inhibit-data
module sd_data_master_mb #(
    parameter int BD_W       = 32,
    parameter int BD_CNT_W   = 8,
    parameter int BD_SLOTS   = 8,
    parameter int BLK_W      = 16,
    parameter int RESEND_MAX = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BD_W-1:0]     bd_tx_dat,
    input  logic [BD_W-1:0]     bd_rx_dat,
    input  logic [BD_CNT_W-1:0] bd_tx_free,
    input  logic [BD_CNT_W-1:0] bd_rx_free,
    input  logic                bd_tx_ack,
    input  logic                bd_rx_ack,
    output logic                bd_tx_re,
    output logic                bd_rx_re,
    output logic                bd_tx_cmp,
    output logic                bd_rx_cmp,
    input  logic [BLK_W-1:0]    blk_cnt,
    input  logic [1:0]          transfer_type,
    input  logic                cmd_busy,
    input  logic                we_ack,
    input  logic                cmd_tsf_err,
    input  logic [4:0]          card_status,
    output logic                we_req,
    output logic [15:0]         cmd_set,
    output logic [31:0]         cmd_arg,
    output logic [31:0]         sys_adr,
    output logic                start_tx_fifo,
    output logic                start_rx_fifo,
    input  logic                tx_empt,
    input  logic                rx_full,
    input  logic                transm_complete,
    input  logic                crc_ok,
    input  logic                busy_n,
    output logic                ack_transfer,
    output logic                d_write,
    output logic                d_read,
    output logic [7:0]          int_status,
    input  logic                int_status_rst,
    output logic                cidat
);

    localparam int DW = 64 / BD_W;
    localparam logic [2:0]          WC_LAST  = 3'(DW - 1);
    localparam logic [BD_CNT_W-1:0] SLOTS_V  = BD_CNT_W'(BD_SLOTS);
    localparam logic [BD_CNT_W-1:0] SLOTS_M1 = BD_CNT_W'(BD_SLOTS - 1);
    localparam logic [7:0]          RESEND_V = 8'(RESEND_MAX);
    localparam logic [BLK_W-1:0]    BLK_ONE  = BLK_W'(1);
    localparam logic [15:0]         CMD12    = 16'h0C1A;

    typedef enum logic [2:0] {
        IDLE, GET_BD, SEND_CMD, WAIT_RESP, XFER, STOP_SEND, STOP_WAIT
    } state_t;

    state_t             state, state_n;
    logic               dir_rx, dir_rx_n;     // 1: servicing the rx queue
    logic               multi, multi_n;       // transfer needs CMD12
    logic               abort_q, abort_n;     // suppress completion pulse
    logic               blk_pend, pend_n;     // block done, waiting for busy_n
    logic [2:0]         word_cnt, word_cnt_n;
    logic [7:0]         resend_cnt, resend_n;
    logic [BLK_W-1:0]   blk_rem, blk_rem_n;
    logic [63:0]        bd_buf, bd_buf_n;
    logic [15:0]        cmd_set_n;
    logic               we_req_n, start_tx_n, start_rx_n, d_write_n, d_read_n;
    logic               ack_n, tx_cmp_n, rx_cmp_n, cidat_n;
    logic [7:0]         int_set, int_n;
    logic               tc_s1, tc_s2, tc_s3, tc_rise;

    logic               bd_ack, fifo_err, blk_gt1, resp_seen, resp_ok, leave;
    logic [BD_W-1:0]    bd_dat;
    logic [BD_CNT_W-1:0] free_sel;

    assign sys_adr  = bd_buf[31:0];
    assign cmd_arg  = bd_buf[63:32];
    assign bd_tx_re = (state == GET_BD) && !dir_rx;
    assign bd_rx_re = (state == GET_BD) &&  dir_rx;
    // tc_s1/tc_s2 synchronise; tc_s3 is the previous sample for edge detection
    assign tc_rise  = tc_s2 && !tc_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;          dir_rx <= 1'b0;       multi <= 1'b0;
            abort_q <= 1'b0;        blk_pend <= 1'b0;     word_cnt <= '0;
            resend_cnt <= '0;       blk_rem <= '0;        bd_buf <= '0;
            cmd_set <= '0;          we_req <= 1'b0;       start_tx_fifo <= 1'b0;
            start_rx_fifo <= 1'b0;  d_write <= 1'b0;      d_read <= 1'b0;
            ack_transfer <= 1'b0;   bd_tx_cmp <= 1'b0;    bd_rx_cmp <= 1'b0;
            int_status <= '0;       cidat <= 1'b0;
            tc_s1 <= 1'b0;          tc_s2 <= 1'b0;        tc_s3 <= 1'b0;
        end else begin
            state <= state_n;       dir_rx <= dir_rx_n;   multi <= multi_n;
            abort_q <= abort_n;     blk_pend <= pend_n;   word_cnt <= word_cnt_n;
            resend_cnt <= resend_n; blk_rem <= blk_rem_n; bd_buf <= bd_buf_n;
            cmd_set <= cmd_set_n;   we_req <= we_req_n;   start_tx_fifo <= start_tx_n;
            start_rx_fifo <= start_rx_n; d_write <= d_write_n; d_read <= d_read_n;
            ack_transfer <= ack_n;  bd_tx_cmp <= tx_cmp_n; bd_rx_cmp <= rx_cmp_n;
            int_status <= int_n;    cidat <= cidat_n;
            tc_s1 <= transm_complete; tc_s2 <= tc_s1;     tc_s3 <= tc_s2;
        end
    end

    always_comb begin
        state_n    = state;      dir_rx_n   = dir_rx;    multi_n    = multi;
        abort_n    = abort_q;    pend_n     = blk_pend;  word_cnt_n = word_cnt;
        resend_n   = resend_cnt; blk_rem_n  = blk_rem;   bd_buf_n   = bd_buf;
        cmd_set_n  = cmd_set;    we_req_n   = we_req;    start_tx_n = start_tx_fifo;
        start_rx_n = start_rx_fifo; d_write_n = d_write; d_read_n   = d_read;
        ack_n      = 1'b0;       tx_cmp_n   = 1'b0;      rx_cmp_n   = 1'b0;
        cidat_n    = cidat;      int_set    = '0;        leave      = 1'b0;

        bd_ack    = dir_rx ? bd_rx_ack  : bd_tx_ack;
        bd_dat    = dir_rx ? bd_rx_dat  : bd_tx_dat;
        free_sel  = dir_rx ? bd_rx_free : bd_tx_free;
        fifo_err  = dir_rx ? rx_full    : tx_empt;
        blk_gt1   = blk_cnt > BLK_ONE;
        // a response is only judged once the command host is idle and either
        // flags a transport error or presents a valid card status
        resp_seen = !cmd_busy && (card_status[0] || cmd_tsf_err);
        resp_ok   = card_status[0] && !cmd_tsf_err &&
                    (card_status[4:1] == 4'd4 || card_status[4:1] == 4'd5 ||
                     card_status[4:1] == 4'd6);

        case (state)
            IDLE: begin
                we_req_n = 1'b0;  d_write_n = 1'b0;  d_read_n = 1'b0;
                start_tx_n = 1'b0; start_rx_n = 1'b0;
                word_cnt_n = '0;  resend_n = '0;     blk_rem_n = '0;
                abort_n = 1'b0;   pend_n = 1'b0;     multi_n = 1'b0;
                if (bd_tx_free != SLOTS_V) begin
                    dir_rx_n = 1'b0; cidat_n = 1'b1; state_n = GET_BD;
                end else if (bd_rx_free != SLOTS_V) begin
                    dir_rx_n = 1'b1; cidat_n = 1'b1; state_n = GET_BD;
                end
            end
            GET_BD: begin
                if (bd_ack) begin
                    for (int i = 0; i < DW; i++)
                        if (word_cnt == 3'(i)) bd_buf_n[i*BD_W +: BD_W] = bd_dat;
                    word_cnt_n = word_cnt + 3'd1;
                    if (word_cnt == WC_LAST) begin
                        state_n   = SEND_CMD;
                        multi_n   = 1'b0;
                        blk_rem_n = BLK_ONE;
                        if (!dir_rx || transfer_type == 2'b00) begin
                            multi_n   = blk_gt1;
                            blk_rem_n = blk_gt1 ? blk_cnt : BLK_ONE;
                        end
                        if (!dir_rx)                    cmd_set_n = blk_gt1 ? 16'h191A : 16'h181A;
                        else if (transfer_type == 2'b00) cmd_set_n = blk_gt1 ? 16'h121A : 16'h111A;
                        else if (transfer_type == 2'b01) cmd_set_n = 16'h0D1A;
                        else                            cmd_set_n = 16'h331A;
                    end
                end
            end
            SEND_CMD, STOP_SEND: begin
                if (we_req) begin
                    if (we_ack) begin
                        we_req_n = 1'b0;
                        state_n  = (state == SEND_CMD) ? WAIT_RESP : STOP_WAIT;
                    end
                end else if (!cmd_busy) begin
                    we_req_n = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (resp_seen) begin
                    if (resp_ok) begin
                        state_n    = XFER;
                        start_tx_n = !dir_rx;  start_rx_n = dir_rx;
                        d_write_n  = !dir_rx;  d_read_n   = dir_rx;
                        pend_n     = 1'b0;
                    end else begin
                        resend_n = resend_cnt + 8'd1;
                        if (resend_cnt + 8'd1 == RESEND_V) begin
                            int_set[4] = 1'b1;
                            start_tx_n = 1'b0; start_rx_n = 1'b0;
                            state_n    = IDLE;
                        end else begin
                            state_n = SEND_CMD;
                        end
                    end
                end
            end
            XFER: begin
                if (tc_rise) begin
                    ack_n  = 1'b1;
                    pend_n = 1'b1;
                end
                if (fifo_err) begin
                    int_set[2] = 1'b1; abort_n = 1'b1; leave = 1'b1;
                end else if (blk_pend && busy_n) begin
                    pend_n = tc_rise;
                    if (!crc_ok) begin
                        int_set[5] = 1'b1; abort_n = 1'b1; leave = 1'b1;
                    end else begin
                        blk_rem_n = blk_rem - BLK_ONE;
                        if (blk_rem == BLK_ONE) begin
                            leave = 1'b1;
                            if (!multi) begin
                                tx_cmp_n   = !dir_rx;
                                rx_cmp_n   = dir_rx;
                                int_set[0] = (free_sel == SLOTS_M1);
                            end
                        end
                    end
                end
                if (leave) begin
                    start_tx_n = 1'b0; start_rx_n = 1'b0;
                    d_write_n  = 1'b0; d_read_n   = 1'b0;
                    pend_n     = 1'b0;
                    if (multi) begin
                        state_n   = STOP_SEND;
                        cmd_set_n = CMD12;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            STOP_WAIT: begin
                if (resp_seen) begin
                    int_set[1] = cmd_tsf_err;
                    if (!abort_q) begin
                        tx_cmp_n = !dir_rx;
                        rx_cmp_n = dir_rx;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // clear beats a same-cycle set
        int_n = int_status_rst ? 8'h00 : (int_status | int_set);
    end

endmodule

// File: tb/tb_sd_data_master_mb.sv
module tb_sd_data_master_mb;

    localparam int SLOTS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel32 = 1'b1;
    logic [31:0] tx_dat = '0, rx_dat = '0;
    logic        tx_ack = 1'b0, rx_ack = 1'b0;
    logic [15:0] blk_cnt = 16'd1;
    logic [1:0]  transfer_type = 2'b00;
    logic        cmd_busy = 1'b0, we_ack = 1'b0, cmd_tsf_err = 1'b0;
    logic [4:0]  card_status = '0;
    logic        tx_empt = 1'b0, rx_full = 1'b0, tc = 1'b0, crc_ok = 1'b0, busy_n = 1'b1;
    logic        int_status_rst = 1'b0;
    int          tx_posted = 0, rx_posted = 0;
    int          n_txcmp = 0, n_rxcmp = 0, n_ack = 0, n_we = 0;
    logic        we_prev = 1'b0;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    logic [7:0] tx_free, rx_free;
    assign tx_free = 8'(SLOTS - (tx_posted - n_txcmp));
    assign rx_free = 8'(SLOTS - (rx_posted - n_rxcmp));

    // outputs of the BD_W=32 instance (a_) and the BD_W=16 instance (b_)
    logic a_tx_re, a_rx_re, a_tx_cmp, a_rx_cmp, a_we_req, a_stx, a_srx, a_ack, a_dw, a_dr, a_cidat;
    logic b_tx_re, b_rx_re, b_tx_cmp, b_rx_cmp, b_we_req, b_stx, b_srx, b_ack, b_dw, b_dr, b_cidat;
    logic [15:0] a_cmd_set, b_cmd_set;
    logic [31:0] a_arg, a_adr, b_arg, b_adr;
    logic [7:0]  a_int, b_int;

    sd_data_master_mb #(.BD_W(32), .BD_CNT_W(8), .BD_SLOTS(SLOTS), .BLK_W(16), .RESEND_MAX(3)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .bd_tx_dat(tx_dat), .bd_rx_dat(rx_dat),
        .bd_tx_free(sel32 ? tx_free : 8'(SLOTS)), .bd_rx_free(sel32 ? rx_free : 8'(SLOTS)),
        .bd_tx_ack(sel32 & tx_ack), .bd_rx_ack(sel32 & rx_ack),
        .bd_tx_re(a_tx_re), .bd_rx_re(a_rx_re), .bd_tx_cmp(a_tx_cmp), .bd_rx_cmp(a_rx_cmp),
        .blk_cnt(blk_cnt), .transfer_type(transfer_type),
        .cmd_busy(cmd_busy), .we_ack(we_ack), .cmd_tsf_err(cmd_tsf_err), .card_status(card_status),
        .we_req(a_we_req), .cmd_set(a_cmd_set), .cmd_arg(a_arg), .sys_adr(a_adr),
        .start_tx_fifo(a_stx), .start_rx_fifo(a_srx), .tx_empt(tx_empt), .rx_full(rx_full),
        .transm_complete(tc), .crc_ok(crc_ok), .busy_n(busy_n),
        .ack_transfer(a_ack), .d_write(a_dw), .d_read(a_dr),
        .int_status(a_int), .int_status_rst(int_status_rst), .cidat(a_cidat)
    );

    sd_data_master_mb #(.BD_W(16), .BD_CNT_W(8), .BD_SLOTS(SLOTS), .BLK_W(16), .RESEND_MAX(3)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .bd_tx_dat(tx_dat[15:0]), .bd_rx_dat(rx_dat[15:0]),
        .bd_tx_free(sel32 ? 8'(SLOTS) : tx_free), .bd_rx_free(sel32 ? 8'(SLOTS) : rx_free),
        .bd_tx_ack(!sel32 & tx_ack), .bd_rx_ack(!sel32 & rx_ack),
        .bd_tx_re(b_tx_re), .bd_rx_re(b_rx_re), .bd_tx_cmp(b_tx_cmp), .bd_rx_cmp(b_rx_cmp),
        .blk_cnt(blk_cnt), .transfer_type(transfer_type),
        .cmd_busy(cmd_busy), .we_ack(we_ack), .cmd_tsf_err(cmd_tsf_err), .card_status(card_status),
        .we_req(b_we_req), .cmd_set(b_cmd_set), .cmd_arg(b_arg), .sys_adr(b_adr),
        .start_tx_fifo(b_stx), .start_rx_fifo(b_srx), .tx_empt(tx_empt), .rx_full(rx_full),
        .transm_complete(tc), .crc_ok(crc_ok), .busy_n(busy_n),
        .ack_transfer(b_ack), .d_write(b_dw), .d_read(b_dr),
        .int_status(b_int), .int_status_rst(int_status_rst), .cidat(b_cidat)
    );

    // view of whichever instance is under test
    logic m_tx_re, m_rx_re, m_tx_cmp, m_rx_cmp, m_we_req, m_stx, m_srx, m_ack, m_dw, m_dr, m_cidat;
    logic [15:0] m_cmd_set;
    logic [31:0] m_arg, m_adr;
    logic [7:0]  m_int;
    assign m_tx_re   = sel32 ? a_tx_re   : b_tx_re;
    assign m_rx_re   = sel32 ? a_rx_re   : b_rx_re;
    assign m_tx_cmp  = sel32 ? a_tx_cmp  : b_tx_cmp;
    assign m_rx_cmp  = sel32 ? a_rx_cmp  : b_rx_cmp;
    assign m_we_req  = sel32 ? a_we_req  : b_we_req;
    assign m_stx     = sel32 ? a_stx     : b_stx;
    assign m_srx     = sel32 ? a_srx     : b_srx;
    assign m_ack     = sel32 ? a_ack     : b_ack;
    assign m_dw      = sel32 ? a_dw      : b_dw;
    assign m_dr      = sel32 ? a_dr      : b_dr;
    assign m_cidat   = sel32 ? a_cidat   : b_cidat;
    assign m_cmd_set = sel32 ? a_cmd_set : b_cmd_set;
    assign m_arg     = sel32 ? a_arg     : b_arg;
    assign m_adr     = sel32 ? a_adr     : b_adr;
    assign m_int     = sel32 ? a_int     : b_int;

    logic any_a, any_b;
    assign any_a = |{a_tx_re, a_rx_re, a_tx_cmp, a_rx_cmp, a_we_req, a_stx, a_srx, a_ack, a_dw, a_dr,
                     a_cidat, a_cmd_set, a_arg, a_adr, a_int};
    assign any_b = |{b_tx_re, b_rx_re, b_tx_cmp, b_rx_cmp, b_we_req, b_stx, b_srx, b_ack, b_dw, b_dr,
                     b_cidat, b_cmd_set, b_arg, b_adr, b_int};

    // pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (m_tx_cmp) n_txcmp <= n_txcmp + 1;
        if (m_rx_cmp) n_rxcmp <= n_rxcmp + 1;
        if (m_ack)    n_ack   <= n_ack + 1;
        if (m_we_req && !we_prev) n_we <= n_we + 1;
        we_prev <= m_we_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // feed one descriptor, nw words, followed by 'extra' stray acks
    task automatic fetch(input bit rx, input logic [63:0] bd, input int nw, input int extra);
        bit seen = 0;
        int w = 64 / nw;
        logic [63:0] mask = (64'h1 << w) - 64'h1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rx ? m_rx_re : m_tx_re) seen = 1;
            else tick(1);
        end
        check("re_rise", 64'(seen), 64'd1);
        for (int i = 0; i < nw + extra; i++) begin
            tx_dat = (i < nw) ? 32'((bd >> (i * w)) & mask) : 32'hDEAD_BEEF;
            rx_dat = tx_dat;
            tx_ack = !rx;
            rx_ack = rx;
            tick(1);
        end
        tx_ack = 1'b0;
        rx_ack = 1'b0;
        check("re_drop", 64'(rx ? m_rx_re : m_tx_re), 64'd0);
    endtask

    task automatic handshake(output logic [15:0] cmd);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (m_we_req) seen = 1;
            else tick(1);
        end
        check("we_req_rise", 64'(seen), 64'd1);
        cmd = m_cmd_set;
        we_ack = 1'b1;
        tick(1);
        we_ack = 1'b0;
        check("we_req_drop", 64'(m_we_req), 64'd0);
    endtask

    task automatic respond(input logic [3:0] st, input bit err);
        card_status = {st, 1'b1};
        cmd_tsf_err = err;
        tick(1);
        card_status = '0;
        cmd_tsf_err = 1'b0;
    endtask

    task automatic do_block(input bit crc);
        tc = 1'b1; crc_ok = crc; busy_n = 1'b1;
        tick(4);
        tc = 1'b0;
        tick(3);
    endtask

    task automatic clear_int();
        int_status_rst = 1'b1;
        tick(1);
        int_status_rst = 1'b0;
        check("int_clear", 64'(m_int), 64'h00);
    endtask

    logic [15:0] cmd;
    int s_tx, s_rx, s_ack, s_we;

    initial begin
        tick(2);
        check("rst_out32", 64'(any_a), 64'd0);
        check("rst_out16", 64'(any_b), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // single-block write, 32-bit descriptor words, last queued descriptor
        sel32 = 1'b1; blk_cnt = 16'd1; tx_posted = 1;
        fetch(0, 64'h0000_1234_8000_0400, 2, 1);
        check("t1_cidat", 64'(m_cidat), 64'd1);
        check("t1_adr", 64'(m_adr), 64'h8000_0400);
        check("t1_arg", 64'(m_arg), 64'h0000_1234);
        handshake(cmd);
        check("t1_cmd", 64'(cmd), 64'h181A);
        respond(4'd4, 1'b0);
        check("t1_start_tx", 64'(m_stx), 64'd1);
        check("t1_d_write", 64'(m_dw), 64'd1);
        s_tx = n_txcmp; s_ack = n_ack;
        do_block(1'b1);
        check("t1_acks", 64'(n_ack - s_ack), 64'd1);
        check("t1_tx_cmp", 64'(n_txcmp - s_tx), 64'd1);
        check("t1_int", 64'(m_int), 64'h01);
        check("t1_d_write_off", 64'(m_dw), 64'd0);
        clear_int();

        // three-block read, 16-bit descriptor words
        sel32 = 1'b0; tick(2);
        blk_cnt = 16'd3; transfer_type = 2'b00; rx_posted = 1;
        fetch(1, 64'hCAFE_0000_0000_1000, 4, 0);
        check("t2_adr", 64'(m_adr), 64'h0000_1000);
        check("t2_arg", 64'(m_arg), 64'hCAFE_0000);
        handshake(cmd);
        check("t2_cmd", 64'(cmd), 64'h121A);
        respond(4'd5, 1'b0);
        check("t2_d_read", 64'(m_dr), 64'd1);
        check("t2_start_rx", 64'(m_srx), 64'd1);
        s_rx = n_rxcmp; s_ack = n_ack;
        for (int b = 0; b < 3; b++) do_block(1'b1);
        check("t2_acks", 64'(n_ack - s_ack), 64'd3);
        handshake(cmd);
        check("t2_cmd12", 64'(cmd), 64'h0C1A);
        check("t2_d_read_off", 64'(m_dr), 64'd0);
        check("t2_rx_cmp_early", 64'(n_rxcmp - s_rx), 64'd0);
        respond(4'd4, 1'b0);
        tick(2);
        check("t2_rx_cmp", 64'(n_rxcmp - s_rx), 64'd1);

        // card keeps answering in the wrong state: retries exhaust
        blk_cnt = 16'd1; tx_posted++;
        fetch(0, 64'h0000_0001_0000_2000, 4, 0);
        tx_posted--;
        s_we = n_we; s_tx = n_txcmp;
        for (int r = 0; r < 3; r++) begin
            handshake(cmd);
            check("t3_cmd", 64'(cmd), 64'h181A);
            respond(4'd7, 1'b0);
        end
        tick(10);
        check("t3_int", 64'(m_int), 64'h10);
        check("t3_we_count", 64'(n_we - s_we), 64'd3);
        check("t3_no_cmp", 64'(n_txcmp - s_tx), 64'd0);
        check("t3_we_idle", 64'(m_we_req), 64'd0);
        check("t3_start_tx", 64'(m_stx), 64'd0);
        clear_int();

        // FIFO underrun during block 2 of a four-block write
        blk_cnt = 16'd4; tx_posted++;
        fetch(0, 64'h0000_0002_0000_3000, 4, 0);
        tx_posted--;
        handshake(cmd);
        check("t4_cmd", 64'(cmd), 64'h191A);
        respond(4'd6, 1'b0);
        s_tx = n_txcmp; s_ack = n_ack;
        do_block(1'b1);
        tc = 1'b1; crc_ok = 1'b1;
        tick(1);
        tx_empt = 1'b1;
        tick(1);
        tx_empt = 1'b0; tc = 1'b0;
        tick(3);
        check("t4_int", 64'(m_int), 64'h04);
        check("t4_acks", 64'(n_ack - s_ack), 64'd1);
        handshake(cmd);
        check("t4_cmd12", 64'(cmd), 64'h0C1A);
        respond(4'd4, 1'b0);
        tick(2);
        check("t4_no_cmp", 64'(n_txcmp - s_tx), 64'd0);
        check("t4_d_write_off", 64'(m_dw), 64'd0);
        clear_int();

        // tx and rx pending together: tx first
        blk_cnt = 16'd1; transfer_type = 2'b01;
        tx_posted++; rx_posted++;
        tick(2);
        check("t5_tx_first", 64'(m_tx_re), 64'd1);
        check("t5_rx_waits", 64'(m_rx_re), 64'd0);
        fetch(0, 64'h0000_0003_0000_4000, 4, 0);
        handshake(cmd);
        respond(4'd4, 1'b0);
        do_block(1'b1);
        check("t5_int_last", 64'(m_int), 64'h01);
        check("t5_rx_next", 64'(m_rx_re), 64'd1);
        fetch(1, 64'h0000_0004_0000_5000, 4, 0);
        handshake(cmd);
        check("t5_acmd13", 64'(cmd), 64'h0D1A);
        respond(4'd4, 1'b0);
        check("t5_d_read", 64'(m_dr), 64'd1);
        s_rx = n_rxcmp;
        // overrun and clear in the same cycle: clear wins
        rx_full = 1'b1; int_status_rst = 1'b1;
        tick(1);
        rx_full = 1'b0; int_status_rst = 1'b0;
        check("t5_rst_wins", 64'(m_int), 64'h00);
        check("t5_abort_idle", 64'(m_dr), 64'd0);
        // the descriptor is still queued, so the transfer restarts
        fetch(1, 64'h0000_0004_0000_5000, 4, 0);
        handshake(cmd);
        respond(4'd4, 1'b0);
        check("t5_xfer_again", 64'(m_dr), 64'd1);
        tc = 1'b1; crc_ok = 1'b1;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out16", 64'(any_b), 64'd0);
        check("t5_rst_out32", 64'(any_a), 64'd0);
        tc = 1'b0; rx_posted--;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("t5_no_cmp", 64'(n_rxcmp - s_rx), 64'd0);
        check("t5_post_rst_idle", 64'(m_rx_re | m_we_req | m_cidat), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
